// File: rtl/slave_i2c_pkg.sv
// Shared definitions for the slave bus condition detector and the slave FSM.
package slave_i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_SETTLE = 2'd2
    } bus_state_e;

    typedef struct packed {
        logic start;
        logic rstart;
        logic stop;
        logic tbuf;
    } bus_pulse_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_FILTER_DEPTH    = 3;
    localparam int DEF_BUS_FREE_CYCLES = 8;
    localparam int DEF_TIMEOUT_CYCLES  = 1000;

endpackage

// File: rtl/slave_glitch_filter.sv
// Per-line synchroniser plus glitch filter; the filtered line only moves after
// the synchronised value has differed for FILTER_DEPTH consecutive cycles.
module slave_glitch_filter #(
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_DEPTH = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic line_o
);

    localparam int CW = $clog2(FILTER_DEPTH) + 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   sync_s;

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign sync_d = {sync_q[SYNC_STAGES-2:0], line_i};

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_s != filt_q) begin
            if (cnt_q == CW'(FILTER_DEPTH - 1)) begin
                filt_d = sync_s;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '1;
            cnt_q  <= '0;
            filt_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign line_o = filt_q;

endmodule

// File: rtl/slave_bus_condition_detector.sv
// Oversampled START / repeated START / STOP detector with bus busy/free tracking.
// Optional SCL-stuck-low timeout is built when SLAVE_BUS_TIMEOUT_EN is defined.
module slave_bus_condition_detector
    import slave_i2c_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int FILTER_DEPTH    = DEF_FILTER_DEPTH,
    parameter int BUS_FREE_CYCLES = DEF_BUS_FREE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic slave_clock,
    input  logic slave_reset,
    input  logic slave_scl_in,
    input  logic slave_sda_in,
    output logic scl_filt,
    output logic sda_filt,
    output logic start_pulse,
    output logic rstart_pulse,
    output logic stop_pulse,
    output logic start_stop_detect,
    output logic bus_busy,
    output logic bus_free,
    output logic tbuf_violation,
    output logic scl_timeout
);

    localparam int FW = $clog2(BUS_FREE_CYCLES) + 1;

    if (SYNC_STAGES < 2 || FILTER_DEPTH < 1 || BUS_FREE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("slave_bus_condition_detector: parameter out of range");
    end

    logic       scl_prev_q, sda_prev_q;
    logic       start_det, stop_det;
    bus_state_e state_q, state_d;
    logic [FW-1:0] free_cnt_q, free_cnt_d;
    bus_pulse_t pulse_q, pulse_d;
    logic       ssd_q;

    slave_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_DEPTH(FILTER_DEPTH)) u_scl_filt (
        .clk_i (slave_clock),
        .rst_i (slave_reset),
        .line_i(slave_scl_in),
        .line_o(scl_filt)
    );

    slave_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_DEPTH(FILTER_DEPTH)) u_sda_filt (
        .clk_i (slave_clock),
        .rst_i (slave_reset),
        .line_i(slave_sda_in),
        .line_o(sda_filt)
    );

    // SCL must be high in both samples, so a simultaneous SCL edge is treated as data.
    assign start_det = scl_prev_q & scl_filt & sda_prev_q & ~sda_filt;
    assign stop_det  = scl_prev_q & scl_filt & ~sda_prev_q & sda_filt;

`ifdef SLAVE_BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_flag_q, tmo_flag_d;
    logic          tmo_hit;

    assign tmo_hit = (state_q == ST_BUSY) && !scl_filt && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_d  = '0;
        tmo_flag_d = tmo_flag_q;
        if (state_q == ST_BUSY && !scl_filt && !tmo_hit)
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        if (tmo_hit)
            tmo_flag_d = 1'b1;
        else if (start_det)
            tmo_flag_d = 1'b0;
    end

    always_ff @(posedge slave_clock) begin
        if (slave_reset) begin
            tmo_cnt_q  <= '0;
            tmo_flag_q <= 1'b0;
        end else begin
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end

    assign scl_timeout = tmo_flag_q;
`else
    logic tmo_hit;
    assign tmo_hit     = 1'b0;
    assign scl_timeout = 1'b0;
`endif

    always_ff @(posedge slave_clock) begin
        if (slave_reset) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            free_cnt_q <= '0;
            pulse_q    <= '0;
            ssd_q      <= 1'b0;
        end else begin
            scl_prev_q <= scl_filt;
            sda_prev_q <= sda_filt;
            state_q    <= state_d;
            free_cnt_q <= free_cnt_d;
            pulse_q    <= pulse_d;
            ssd_q      <= pulse_d.start | pulse_d.rstart | pulse_d.stop;
        end
    end

    always_comb begin
        state_d    = state_q;
        free_cnt_d = free_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_det) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (stop_det) begin
                    state_d    = ST_SETTLE;
                    free_cnt_d = '0;
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (start_det) begin
                    state_d    = ST_BUSY;
                    free_cnt_d = '0;
                end else if (scl_filt && sda_filt) begin
                    if (free_cnt_q >= FW'(BUS_FREE_CYCLES - 1)) begin
                        state_d    = ST_IDLE;
                        free_cnt_d = '0;
                    end else begin
                        free_cnt_d = free_cnt_q + FW'(1);
                    end
                end else begin
                    free_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                free_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        pulse_d      = '0;
        pulse_d.stop = stop_det;
        case (state_q)
            ST_IDLE:   pulse_d.start  = start_det;
            ST_BUSY:   pulse_d.rstart = start_det;
            ST_SETTLE: begin
                pulse_d.start = start_det;
                pulse_d.tbuf  = start_det;
            end
            default:   pulse_d = '0;
        endcase
        bus_busy = (state_q == ST_BUSY);
        bus_free = (state_q == ST_IDLE);
    end

    assign start_pulse       = pulse_q.start;
    assign rstart_pulse      = pulse_q.rstart;
    assign stop_pulse        = pulse_q.stop;
    assign tbuf_violation    = pulse_q.tbuf;
    assign start_stop_detect = ssd_q;

endmodule
